// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads a 1-cycle-latency instruction memory and feeds decode through a 1-entry skid buffer.
// Optional FETCH_PERF_EN adds saturating fetch/redirect counters.
module instruction_fetch #(
    parameter int               PC_W      = 8,
    parameter logic [PC_W-1:0]  RESET_PC  = '0,
    parameter logic [23:0]      NOP_INSTR = 24'h000000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [23:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            halt,
    output logic [23:0]     instr,
    output logic [PC_W-1:0] instr_pc,
    output logic            instr_valid,
    output logic            halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]     perf_fetches,
    output logic [15:0]     perf_redirects
`endif
);

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] fetch_pc;
    logic            inflight;
    logic [PC_W-1:0] inflight_pc;
    logic            skid_valid;
    logic [23:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic            sample, take_redirect, take_halt;

    // Decode's back-signals only count for a real instruction that is actually moving on.
    assign sample        = (state == RUN) && !stall && instr_valid;
    assign take_redirect = sample && redirect;
    assign take_halt     = sample && halt && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (take_halt) state_next = HALTED;
    end

    always_comb begin
        imem_en   = (state == RUN) && !stall && !(redirect && instr_valid) && !(halt && instr_valid);
        imem_addr = fetch_pc;
        halted    = (state == HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc     <= '0;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (imem_en) begin
                fetch_pc    <= fetch_pc + 1'b1;
                inflight    <= 1'b1;
                inflight_pc <= fetch_pc;
            end else begin
                inflight <= 1'b0;
            end

            // Redirect and halt drop whatever is in flight or parked; halt leaves the outputs frozen.
            if (take_redirect) begin
                fetch_pc    <= redirect_pc;
                skid_valid  <= 1'b0;
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end else if (take_halt) begin
                skid_valid <= 1'b0;
            end else if (state == RUN) begin
                if (stall) begin
                    if (inflight) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= inflight_pc;
                        skid_valid <= 1'b1;
                    end
                end else if (skid_valid) begin
                    instr       <= skid_instr;
                    instr_pc    <= skid_pc;
                    instr_valid <= 1'b1;
                    skid_valid  <= 1'b0;
                end else if (inflight) begin
                    instr       <= imem_rdata;
                    instr_pc    <= inflight_pc;
                    instr_valid <= 1'b1;
                end else begin
                    instr       <= NOP_INSTR;
                    instr_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetches   <= '0;
            perf_redirects <= '0;
        end else begin
            if (imem_en && perf_fetches != 16'hFFFF)
                perf_fetches <= perf_fetches + 16'd1;
            if (take_redirect && perf_redirects != 16'hFFFF)
                perf_redirects <= perf_redirects + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for startup/stall/redirect/halt plus hand sequences for halt hold and reset.
// A second instance with RESET_PC=8'hFE covers PC wrap-around.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, halt;
    logic [7:0]  redirect_pc;
    logic        imem_en, imem_en2;
    logic [7:0]  imem_addr, imem_addr2;
    logic [23:0] imem_rdata, imem_rdata2;
    logic [23:0] instr, instr2;
    logic [7:0]  instr_pc, instr_pc2;
    logic        instr_valid, instr_valid2;
    logic        halted, halted2;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetches, perf_redirects, perf_fetches2, perf_redirects2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.PC_W(8), .RESET_PC(8'h00), .NOP_INSTR(24'h000000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .halted(halted)
`ifdef FETCH_PERF_EN
        , .perf_fetches(perf_fetches), .perf_redirects(perf_redirects)
`endif
    );

    instruction_fetch #(.PC_W(8), .RESET_PC(8'hFE), .NOP_INSTR(24'h000000)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2), .halted(halted2)
`ifdef FETCH_PERF_EN
        , .perf_fetches(perf_fetches2), .perf_redirects(perf_redirects2)
`endif
    );

    // Instruction memory contents are mem[a] = 24'h100000 + a.
    always @(posedge clk) begin
        if (imem_en)  imem_rdata  <= {16'h1000, imem_addr};
        if (imem_en2) imem_rdata2 <= {16'h1000, imem_addr2};
    end

    typedef struct {
        logic       stall, redirect, halt;
        logic [7:0] rpc;
        logic       en, valid;
        logic [7:0] pc;
        logic       hlt;
        logic       chk2, valid2;
        logic [7:0] pc2;
    } vec_t;

    vec_t vecs[16];

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string tag, input logic v, input logic [7:0] pc, input logic h);
        check_val({tag, " valid"}, instr_valid, v);
        if (v) begin
            check_val({tag, " pc"}, instr_pc, pc);
            check_val({tag, " instr"}, instr, {16'h1000, pc});
        end else begin
            check_val({tag, " instr"}, instr, 24'h000000);
        end
        check_val({tag, " halted"}, halted, h);
    endtask

    // Drive one cycle at a negedge, check imem_en before the edge and the registered outputs after it.
    task automatic apply_stimulus(input vec_t v, input string tag);
        stall       = v.stall;
        redirect    = v.redirect;
        halt        = v.halt;
        redirect_pc = v.rpc;
        #1;
        check_val({tag, " imem_en"}, imem_en, v.en);
        @(posedge clk);
        #1;
        check_output(tag, v.valid, v.pc, v.hlt);
        if (v.chk2) begin
            check_val({tag, " wrap valid"}, instr_valid2, v.valid2);
            if (v.valid2) check_val({tag, " wrap pc"}, instr_pc2, v.pc2);
        end
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic s, input logic en, input logic v, input logic [7:0] pc);
        vec_t r;
        r = '{s, 1'b0, 1'b0, 8'h00, en, v, pc, 1'b0, 1'b0, 1'b0, 8'h00};
        return r;
    endfunction

    int fetch_count;

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0; redirect_pc = 8'h00;

        //         stall redir halt rpc    en    valid pc     hlt   chk2  v2    pc2
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFE};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'hFF};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check_output("reset", 1'b0, 8'h00, 1'b0);
        check_val("reset pc", instr_pc, 8'h00);
`ifdef FETCH_PERF_EN
        check_val("reset perf_fetches", perf_fetches, 16'd0);
        check_val("reset perf_redirects", perf_redirects, 16'd0);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        fetch_count = 0;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
            if (vecs[i].en) fetch_count++;
        end
`ifdef FETCH_PERF_EN
        check_val("perf_fetches", perf_fetches, fetch_count);
        check_val("perf_redirects", perf_redirects, 1);
`endif

        // Halted: no fetches and outputs frozen regardless of stall.
        for (int k = 0; k < 20; k++) begin
            apply_stimulus('{(k % 3 == 0), 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0, 8'h00},
                           $sformatf("halthold%0d", k));
        end

        // Async reset out of HALTED clears everything without waiting for an edge.
        rst_n = 1'b0;
        #1;
        check_output("reset_from_halt", 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(mk(1'b0, 1'b1, 1'b0, 8'h00), "restart0");
        apply_stimulus(mk(1'b0, 1'b1, 1'b1, 8'h00), "restart1");
        apply_stimulus(mk(1'b0, 1'b1, 1'b1, 8'h01), "restart2");
        apply_stimulus(mk(1'b1, 1'b0, 1'b1, 8'h01), "stall_fill");

        // Skid now holds pc 2; reset mid-cycle must discard it.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_output("reset_midstall", 1'b0, 8'h00, 1'b0);
`ifdef FETCH_PERF_EN
        check_val("midstall perf_fetches", perf_fetches, 16'd0);
        check_val("midstall perf_redirects", perf_redirects, 16'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(mk(1'b0, 1'b1, 1'b0, 8'h00), "after_rst0");
        apply_stimulus(mk(1'b0, 1'b1, 1'b1, 8'h00), "after_rst1");
        apply_stimulus(mk(1'b0, 1'b1, 1'b1, 8'h01), "after_rst2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
